// File: rtl/vx_flush_ctrl.sv
// Tag-store flush controller: walks every line with a valid-clearing write on request.
// Build option VX_FLUSH_ON_RESET_EN: reset starts an INIT walk instead of going straight to IDLE.
module vx_flush_ctrl #(
  parameter int LINES_PER_BANK = 64,
  parameter int LINE_SEL_BITS  = (LINES_PER_BANK > 1) ? $clog2(LINES_PER_BANK) : 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush_valid,
  output logic                     flush_ready,
  output logic                     flush_done,
  output logic                     busy,
  input  logic                     core_valid,
  input  logic                     core_fill,
  input  logic [LINE_SEL_BITS-1:0] core_addr,
  output logic                     core_ready,
  output logic                     tag_fill,
  output logic                     tag_is_flush,
  output logic                     tag_lookup,
  output logic [LINE_SEL_BITS-1:0] tag_addr
);

  typedef enum logic [1:0] {
    ST_INIT,
    ST_IDLE,
    ST_FLUSH
  } state_t;

`ifdef VX_FLUSH_ON_RESET_EN
  localparam state_t RESET_STATE = ST_INIT;
`else
  localparam state_t RESET_STATE = ST_IDLE;
`endif

  localparam logic [LINE_SEL_BITS-1:0] LAST_LINE = LINE_SEL_BITS'(LINES_PER_BANK - 1);

  state_t                   state_q, state_d;
  logic [LINE_SEL_BITS-1:0] cnt_q, cnt_d;
  logic                     done_q, done_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RESET_STATE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    done_d       = 1'b0;
    flush_ready  = 1'b0;
    core_ready   = 1'b0;
    busy         = 1'b1;
    tag_fill     = 1'b0;
    tag_is_flush = 1'b0;
    tag_lookup   = 1'b0;
    tag_addr     = cnt_q;

    unique case (state_q)
      ST_IDLE: begin
        flush_ready = 1'b1;
        core_ready  = 1'b1;
        busy        = 1'b0;
        tag_fill    = core_valid & core_fill;
        tag_lookup  = core_valid & ~core_fill;
        tag_addr    = core_addr;
        if (flush_valid) begin
          state_d = ST_FLUSH;
        end
      end
      ST_INIT, ST_FLUSH: begin
        tag_fill     = 1'b1;
        tag_is_flush = 1'b1;
        if (cnt_q == LAST_LINE) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
          // Only a requested flush reports completion; the reset-time walk is silent.
          done_d  = (state_q == ST_FLUSH);
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = RESET_STATE;
        cnt_d   = '0;
      end
    endcase

    // Reset masks every strobe combinationally so nothing leaks out before the state settles.
    if (reset) begin
      flush_ready  = 1'b0;
      core_ready   = 1'b0;
      busy         = 1'b1;
      tag_fill     = 1'b0;
      tag_is_flush = 1'b0;
      tag_lookup   = 1'b0;
    end
    flush_done = done_q & ~reset;
  end

endmodule

// File: tb/tb_vx_flush_ctrl.sv
// Scoreboard bench for vx_flush_ctrl: an L=4 instance and an L=1 instance share stimulus.
// Expectations follow VX_FLUSH_ON_RESET_EN when the bench is built with it.
module tb_vx_flush_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       flush_valid = 1'b0;
  logic       core_valid = 1'b0;
  logic       core_fill = 1'b0;
  logic [2:0] core_addr = '0;

  always #5 clk = ~clk;

  logic       a_flush_ready, a_flush_done, a_busy, a_core_ready;
  logic       a_tag_fill, a_tag_is_flush, a_tag_lookup;
  logic [2:0] a_tag_addr;
  logic       b_flush_ready, b_flush_done, b_busy, b_core_ready;
  logic       b_tag_fill, b_tag_is_flush, b_tag_lookup;
  logic [0:0] b_tag_addr;
  logic [0:0] b_core_addr;

  assign b_core_addr = core_addr[0:0];

  vx_flush_ctrl #(.LINES_PER_BANK(4), .LINE_SEL_BITS(3)) u_dut4 (
    .clk(clk), .reset(reset),
    .flush_valid(flush_valid), .flush_ready(a_flush_ready), .flush_done(a_flush_done),
    .busy(a_busy), .core_valid(core_valid), .core_fill(core_fill), .core_addr(core_addr),
    .core_ready(a_core_ready), .tag_fill(a_tag_fill), .tag_is_flush(a_tag_is_flush),
    .tag_lookup(a_tag_lookup), .tag_addr(a_tag_addr)
  );

  vx_flush_ctrl #(.LINES_PER_BANK(1)) u_dut1 (
    .clk(clk), .reset(reset),
    .flush_valid(flush_valid), .flush_ready(b_flush_ready), .flush_done(b_flush_done),
    .busy(b_busy), .core_valid(core_valid), .core_fill(core_fill), .core_addr(b_core_addr),
    .core_ready(b_core_ready), .tag_fill(b_tag_fill), .tag_is_flush(b_tag_is_flush),
    .tag_lookup(b_tag_lookup), .tag_addr(b_tag_addr)
  );

  // Vector layout: [9]flush_ready [8]flush_done [7]busy [6]core_ready [5]tag_fill
  // [4]tag_is_flush [3]tag_lookup [2:0]tag_addr
  function automatic logic [15:0] mk(logic fr, logic fd, logic bz, logic cr, logic tf,
                                     logic tif, logic tl, logic [2:0] a);
    return {6'b0, fr, fd, bz, cr, tf, tif, tl, a};
  endfunction

  function automatic logic [15:0] e_idle(logic fd, logic cv, logic cf, logic [2:0] ca);
    return mk(1'b1, fd, 1'b0, 1'b1, cv & cf, 1'b0, cv & ~cf, ca);
  endfunction

  function automatic logic [15:0] e_walk(logic [2:0] a);
    return mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, a);
  endfunction

  localparam logic [15:0] E_RST = 16'h0080;

  logic [15:0] got4, got1;
  assign got4 = mk(a_flush_ready, a_flush_done, a_busy, a_core_ready, a_tag_fill,
                   a_tag_is_flush, a_tag_lookup, a_tag_addr);
  assign got1 = mk(b_flush_ready, b_flush_done, b_busy, b_core_ready, b_tag_fill,
                   b_tag_is_flush, b_tag_lookup, {2'b00, b_tag_addr});

  logic        sb_sel[$];
  logic [15:0] sb_exp[$];
  logic [15:0] sb_mask[$];
  string       sb_tag[$];

  int checks = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (sb_exp.size() > 0) begin
      logic        s;
      logic [15:0] e, m;
      string       t;
      s = sb_sel.pop_front();
      e = sb_exp.pop_front();
      m = sb_mask.pop_front();
      t = sb_tag.pop_front();
      check_eq(t, (s ? got1 : got4) & m, e & m);
    end
  end

  // One cycle of stimulus plus the outputs expected during that same cycle.
  task automatic cyc(input logic sel, input logic rst, input logic fv, input logic cv,
                     input logic cf, input logic [2:0] ca, input logic [15:0] exp,
                     input string tag);
    @(posedge clk);
    #1;
    reset       = rst;
    flush_valid = fv;
    core_valid  = cv;
    core_fill   = cf;
    core_addr   = ca;
    sb_sel.push_back(sel);
    sb_exp.push_back(exp);
    sb_mask.push_back(rst ? 16'hFFF8 : 16'hFFFF);
    sb_tag.push_back(tag);
  endtask

  task automatic walk4(input logic fv, input string tag);
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, 1'b0, fv, 1'b1, i[0], 3'd6, e_walk(3'(i)), tag);
    end
  endtask

  task automatic after_reset(input logic sel, input int lines);
`ifdef VX_FLUSH_ON_RESET_EN
    for (int i = 0; i < lines; i++) begin
      cyc(sel, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, e_walk(3'(i)), "init_walk");
    end
`else
    if (lines < 0) $display("unreachable");
`endif
    cyc(sel, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, e_idle(1'b0, 1'b0, 1'b0, 3'd0), "first_idle");
  endtask

  initial begin
    #200000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "simulation time limit reached");
  end

  initial begin
    // Reset with requests active: every strobe must stay low.
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 3'd2, E_RST, "reset_hold");
    after_reset(1'b0, 4);

    // Core pass-through in IDLE.
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 3'd2, e_idle(1'b0, 1'b1, 1'b1, 3'd2), "idle_fill");
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd7, e_idle(1'b0, 1'b1, 1'b0, 3'd7), "idle_lookup");
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd3, e_idle(1'b0, 1'b0, 1'b1, 3'd3), "idle_nocore");

    // Single flush; core requests during the walk must be blocked.
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, e_idle(1'b0, 1'b0, 1'b0, 3'd0), "flush_accept");
    walk4(1'b0, "flush_walk");
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd1, e_idle(1'b1, 1'b0, 1'b0, 3'd1), "flush_done");
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd1, e_idle(1'b0, 1'b0, 1'b0, 3'd1), "done_once");

    // Core lookup and flush in the same cycle, then flush held high back-to-back.
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 3'd5, e_idle(1'b0, 1'b1, 1'b0, 3'd5), "core_and_flush");
    walk4(1'b1, "held_walk1");
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, e_idle(1'b1, 1'b0, 1'b0, 3'd0), "held_done1");
    walk4(1'b1, "held_walk2");
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, e_idle(1'b1, 1'b0, 1'b0, 3'd0), "held_done2");
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 3'd4, e_idle(1'b0, 1'b1, 1'b1, 3'd4), "post_held_idle");

    // Reset at line 2 of a flush aborts it with no completion pulse.
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, e_idle(1'b0, 1'b0, 1'b0, 3'd0), "abort_accept");
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, e_walk(3'd0), "abort_walk");
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, e_walk(3'd1), "abort_walk");
    cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 3'd0, E_RST, "abort_reset");
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, E_RST, "abort_reset");
    after_reset(1'b0, 4);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, e_idle(1'b0, 1'b0, 1'b0, 3'd0), "abort_no_done");

    // Single-line bank.
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, E_RST, "l1_reset");
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, E_RST, "l1_reset");
    after_reset(1'b1, 1);
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, e_idle(1'b0, 1'b0, 1'b0, 3'd0), "l1_accept");
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 3'd0, e_walk(3'd0), "l1_walk");
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, e_idle(1'b1, 1'b0, 1'b0, 3'd0), "l1_done");
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, e_idle(1'b0, 1'b0, 1'b0, 3'd0), "l1_done_once");

    for (int i = 0; i < 10 && sb_exp.size() > 0; i++) @(negedge clk);
    #1;
    check_eq("sb_drain", 16'(sb_exp.size()), 16'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
